// File: rtl/inference_sequencer.sv
// Runs one inference on an external regnet: buffers a host-loaded image, resets the
// network, streams the image in beats, then returns the label or a timeout flag.
module inference_sequencer #(
    parameter int INTEGER_WIDTH  = 16,
    parameter int FRACTION_WIDTH = 16,
    parameter int NUM_PIXELS     = 10,
    parameter int INPUT_SIZE     = 1,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int W = INTEGER_WIDTH + FRACTION_WIDTH,
    localparam int L = $clog2(NUM_CLASSES)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    input  logic         start,
    output logic         busy,
    output logic         net_reset,
    output logic         net_image_ready,
    output logic [W-1:0] net_pixels [INPUT_SIZE],
    input  logic [L-1:0] net_label,
    input  logic         net_label_ready,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [L-1:0] result_label,
    output logic         result_timeout
);

    localparam int NUM_BEATS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
    localparam int IDXW      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int BEATW     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int WAITW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        CLEAR,
        STREAM,
        WAIT,
        RESULT
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] load_idx_q;
    logic [BEATW-1:0] beat_idx_q;
    logic [WAITW-1:0] wait_cnt_q;
    logic            net_reset_q;
    logic [L-1:0]    result_label_q;
    logic            result_timeout_q;
    logic [W-1:0]    buffer_q [NUM_PIXELS];

    // The frame buffer is deliberately left out of reset; it is fully rewritten before every run.
    always_ff @(posedge clock) begin
        if (reset_n && state_q == IDLE && load_valid) begin
            buffer_q[load_idx_q] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            load_idx_q       <= '0;
            beat_idx_q       <= '0;
            wait_cnt_q       <= '0;
            net_reset_q      <= 1'b1;
            result_label_q   <= '0;
            result_timeout_q <= 1'b0;
        end else begin
            net_reset_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        if (load_idx_q == IDXW'(NUM_PIXELS - 1)) begin
                            load_idx_q <= '0;
                            state_q    <= LOADED;
                        end else begin
                            load_idx_q <= load_idx_q + 1'b1;
                        end
                    end
                end
                LOADED: begin
                    if (start) begin
                        net_reset_q <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    beat_idx_q <= '0;
                    state_q    <= STREAM;
                end
                STREAM: begin
                    if (beat_idx_q == BEATW'(NUM_BEATS - 1)) begin
                        wait_cnt_q <= '0;
                        state_q    <= WAIT;
                    end else begin
                        beat_idx_q <= beat_idx_q + 1'b1;
                    end
                end
                WAIT: begin
                    // A label arriving on the expiry cycle still counts as a real result.
                    if (net_label_ready) begin
                        result_label_q   <= net_label;
                        result_timeout_q <= 1'b0;
                        state_q          <= RESULT;
                    end else if (wait_cnt_q == WAITW'(TIMEOUT_CYCLES - 1)) begin
                        result_label_q   <= '0;
                        result_timeout_q <= 1'b1;
                        net_reset_q      <= 1'b1;
                        state_q          <= RESULT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        load_idx_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Beat lanes past the end of the image are padded with zero.
    always_comb begin
        for (int i = 0; i < INPUT_SIZE; i++) begin
            net_pixels[i] = '0;
            if (state_q == STREAM && (int'(beat_idx_q) * INPUT_SIZE + i) < NUM_PIXELS) begin
                net_pixels[i] = buffer_q[IDXW'(int'(beat_idx_q) * INPUT_SIZE + i)];
            end
        end
    end

    assign load_ready      = (state_q == IDLE);
    assign busy            = (state_q == CLEAR) || (state_q == STREAM) ||
                             (state_q == WAIT) || (state_q == RESULT);
    assign net_reset       = net_reset_q;
    assign net_image_ready = (state_q == STREAM);
    assign result_valid    = (state_q == RESULT);
    assign result_label    = result_label_q;
    assign result_timeout  = result_timeout_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomized scoreboard bench for inference_sequencer: the stimulus side queues expected
// beats and results, an independent monitor compares them as the DUT presents them.
module tb_inference_sequencer;

    localparam int W  = 32;
    localparam int NP = 10;
    localparam int IS = 3;
    localparam int NC = 10;
    localparam int TO = 16;
    localparam int L  = $clog2(NC);
    localparam int NB = (NP + IS - 1) / IS;

    logic         clock;
    logic         reset_n;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         start;
    logic         busy;
    logic         net_reset;
    logic         net_image_ready;
    logic [W-1:0] net_pixels [IS];
    logic [L-1:0] net_label;
    logic         net_label_ready;
    logic         result_valid;
    logic         result_ready;
    logic [L-1:0] result_label;
    logic         result_timeout;

    inference_sequencer #(
        .INTEGER_WIDTH (16),
        .FRACTION_WIDTH(16),
        .NUM_PIXELS    (NP),
        .INPUT_SIZE    (IS),
        .NUM_CLASSES   (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .start          (start),
        .busy           (busy),
        .net_reset      (net_reset),
        .net_image_ready(net_image_ready),
        .net_pixels     (net_pixels),
        .net_label      (net_label),
        .net_label_ready(net_label_ready),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_label   (result_label),
        .result_timeout (result_timeout)
    );

    typedef struct {
        bit           timeout;
        logic [L-1:0] label;
        int           latency;
        int           resets;
    } res_t;

    logic [IS*W-1:0] beatQ [$];
    res_t            resQ [$];
    logic [W-1:0]    pixels [NP];
    int              checks = 0;
    int              errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT shows a beat or a new result.
    int           sinceBeat = 0;
    bit           prevValid = 0;
    bit           haveCur = 0;
    int           resetCount = 0;
    res_t         cur;
    logic [L-1:0] heldLabel;
    logic         heldTimeout;
    logic [IS*W-1:0] expBeat;
    bit           anyNonZero;

    always @(negedge clock) begin
        if (!reset_n) begin
            prevValid  = 0;
            haveCur    = 0;
            resetCount = 0;
        end else begin
            if (net_reset && busy) resetCount++;
            if (net_image_ready) begin
                checkOutput("load_ready_in_stream", {63'd0, load_ready}, 64'd0);
                if (beatQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    expBeat = beatQ.pop_front();
                    for (int i = 0; i < IS; i++)
                        checkOutput("beat_pixel", {32'd0, net_pixels[i]}, {32'd0, expBeat[i*W +: W]});
                end
                sinceBeat = 0;
            end else begin
                anyNonZero = 0;
                for (int i = 0; i < IS; i++) if (net_pixels[i] != '0) anyNonZero = 1;
                checkOutput("pixels_zero_when_idle", {63'd0, anyNonZero}, 64'd0);
                sinceBeat++;
            end
            if (result_valid) begin
                checkOutput("load_ready_in_result", {63'd0, load_ready}, 64'd0);
                if (!prevValid) begin
                    if (resQ.size() == 0) begin
                        checkOutput("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        cur = resQ.pop_front();
                        haveCur = 1;
                        checkOutput("result_label", 64'(result_label), 64'(cur.label));
                        checkOutput("result_timeout", {63'd0, result_timeout}, {63'd0, cur.timeout});
                        checkOutput("result_latency", 64'(sinceBeat), 64'(cur.latency));
                    end
                    heldLabel   = result_label;
                    heldTimeout = result_timeout;
                end else begin
                    checkOutput("label_stable", 64'(result_label), 64'(heldLabel));
                    checkOutput("timeout_stable", {63'd0, result_timeout}, {63'd0, heldTimeout});
                end
                if (result_ready && haveCur) begin
                    checkOutput("net_reset_pulses", 64'(resetCount), 64'(cur.resets));
                    resetCount = 0;
                    haveCur = 0;
                end
            end
            prevValid = result_valid;
        end
    end

    task automatic pushBeats(input int count);
        logic [IS*W-1:0] b;
        for (int k = 0; k < count; k++) begin
            b = '0;
            for (int i = 0; i < IS; i++)
                if (k * IS + i < NP) b[i*W +: W] = pixels[k * IS + i];
            beatQ.push_back(b);
        end
    endtask

    task automatic loadPixels(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            load_valid = 1'b1;
            load_data  = pixels[i];
            step();
        end
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    // One full run: labelDelay < 0 means the network never answers.
    task automatic applyStimulus(input int firstIdx, input int labelDelay, input logic [L-1:0] label,
                                 input int hold, input bit misuse);
        res_t r;
        int   n;
        pushBeats(NB);
        r.timeout = (labelDelay < 0);
        r.label   = r.timeout ? '0 : label;
        r.latency = r.timeout ? TO + 1 : labelDelay + 2;
        r.resets  = r.timeout ? 2 : 1;
        resQ.push_back(r);

        n = 0;
        while (!load_ready && n < 50) begin step(); n++; end
        if (!load_ready) checkOutput("load_ready_wait", 64'd0, 64'd1);
        loadPixels(firstIdx, NP - 1);
        start = 1'b1;
        step();
        start = 1'b0;
        if (misuse) begin
            load_valid      = 1'b1;
            load_data       = W'($urandom);
            net_label_ready = 1'b1;
            net_label       = L'($urandom_range(0, NC - 1));
        end
        n = 0;
        while (!net_image_ready && n < 5) begin step(); n++; end
        n = 0;
        while (net_image_ready && n < NB + 3) begin step(); n++; end
        if (net_image_ready) checkOutput("stream_end_wait", 64'd1, 64'd0);
        net_label_ready = 1'b0;
        if (labelDelay >= 0) begin
            repeat (labelDelay) step();
            net_label_ready = 1'b1;
            net_label       = label;
            step();
            net_label_ready = 1'b0;
            net_label       = L'($urandom_range(0, NC - 1));
        end
        n = 0;
        while (!result_valid && n < TO + 5) begin step(); n++; end
        if (!result_valid) checkOutput("result_valid_wait", 64'd0, 64'd1);
        repeat (hold) step();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        load_valid   = 1'b0;
        checkOutput("load_ready_after_handshake", {63'd0, load_ready}, 64'd1);
    endtask

    task automatic randomPixels();
        for (int i = 0; i < NP; i++) pixels[i] = W'($urandom);
    endtask

    initial begin
        reset_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
        net_label = '0; net_label_ready = 1'b0; result_ready = 1'b0;
        repeat (3) step();
        checkOutput("reset_load_ready", {63'd0, load_ready}, 64'd1);
        checkOutput("reset_net_reset", {63'd0, net_reset}, 64'd1);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_image_ready", {63'd0, net_image_ready}, 64'd0);
        checkOutput("reset_result_valid", {63'd0, result_valid}, 64'd0);
        checkOutput("reset_result_timeout", {63'd0, result_timeout}, 64'd0);
        checkOutput("reset_result_label", 64'(result_label), 64'd0);
        reset_n = 1'b1;
        step();

        $display("[TB] nominal run");
        for (int i = 0; i < NP; i++) pixels[i] = W'(i) << 16;
        applyStimulus(0, 5, L'(7), 0, 0);

        $display("[TB] timeout run");
        randomPixels();
        applyStimulus(0, -1, '0, 2, 0);

        $display("[TB] backpressure run");
        randomPixels();
        applyStimulus(0, 0, L'(3), 5, 0);

        $display("[TB] label on the expiry cycle");
        randomPixels();
        applyStimulus(0, TO - 1, L'(9), 1, 0);

        $display("[TB] loads and label during stream");
        randomPixels();
        applyStimulus(0, 2, L'(4), 3, 1);

        $display("[TB] start after partial load");
        randomPixels();
        loadPixels(0, 5);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("partial_start_load_ready", {63'd0, load_ready}, 64'd1);
            checkOutput("partial_start_net_reset", {63'd0, net_reset}, 64'd0);
        end
        start = 1'b0;
        applyStimulus(6, 1, L'(2), 0, 0);

        $display("[TB] reset mid-stream");
        randomPixels();
        loadPixels(0, NP - 1);
        pushBeats(2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        checkOutput("midreset_image_ready", {63'd0, net_image_ready}, 64'd0);
        checkOutput("midreset_net_reset", {63'd0, net_reset}, 64'd1);
        checkOutput("midreset_load_ready", {63'd0, load_ready}, 64'd1);
        reset_n = 1'b1;
        step();
        randomPixels();
        applyStimulus(0, 3, L'(5), 0, 0);

        $display("[TB] randomized back-to-back runs");
        for (int k = 0; k < 10; k++) begin
            int d;
            randomPixels();
            d = int'($urandom_range(0, TO)) - 1;
            applyStimulus(0, d, L'($urandom_range(0, NC - 1)), int'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)));
        end

        repeat (3) step();
        checkOutput("beat_queue_drained", 64'(beatQ.size()), 64'd0);
        checkOutput("result_queue_drained", 64'(resQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Controller that owns one `regnet` instance and runs complete inferences on it. A host loads one image, one pixel at a time, into an internal frame buffer, then pulses `start`. The block resets the network, streams the image `INPUT_SIZE` pixels per cycle under `net_image_ready`, and waits for `net_label_ready` with a timeout. It then returns the label, or a timeout flag, on a valid/ready result port.

## Interface
- `INTEGER_WIDTH`, default 16: integer bits of the signed fixed-point pixel.
- `FRACTION_WIDTH`, default 16: fraction bits; pixel width W = INTEGER_WIDTH+FRACTION_WIDTH.
- `NUM_PIXELS`, default 10: pixels per image; equals the size of the network's input layer.
- `INPUT_SIZE`, default 1: pixels per stream beat; equals the network's `INPUT_SIZE`.
- `NUM_CLASSES`, default 10: size of the network's output layer; L = $clog2(NUM_CLASSES).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent in WAIT.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  pixel write request.
- `load_ready`  out  1  buffer accepting pixels.
- `load_data`  in  W  signed pixel.
- `start`  in  1  begin inference; single-cycle or level.
- `busy`  out  1  high in CLEAR, STREAM, WAIT and RESULT.
- `net_reset`  out  1  active-high reset to `regnet`.
- `net_image_ready`  out  1  stream beat valid.
- `net_pixels`  out  INPUT_SIZE x W  unpacked array of beat pixels.
- `net_label`  in  L  network label.
- `net_label_ready`  in  1  network label valid.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  host takes result.
- `result_label`  out  L  captured label.
- `result_timeout`  out  1  result is a timeout, not a label.

## Operation
- States: IDLE, LOADED, CLEAR, STREAM, WAIT, RESULT. Buffer: NUM_PIXELS x W registers. Counters: `load_idx`, `beat_idx`, `wait_cnt`.
- **IDLE:** `load_ready`=1.
  - Each handshake (`load_valid` & `load_ready`) writes `buffer[load_idx]` and increments `load_idx`.
  - The write at index NUM_PIXELS-1 moves to LOADED.
  - `start` is ignored in IDLE.
- **LOADED:** `load_ready`=0. `start`=1 moves to CLEAR.
- **CLEAR:** one cycle with `net_reset`=1, then STREAM.
- **STREAM:** NUM_BEATS = ceil(NUM_PIXELS/INPUT_SIZE) consecutive cycles with `net_image_ready`=1.
  - On beat b, `net_pixels[i]` = `buffer[b*INPUT_SIZE+i]`, or 0 when that index is ≥ NUM_PIXELS.
  - `net_label_ready` is ignored during STREAM.
  - After the last beat, move to WAIT.
- **WAIT:** `net_image_ready`=0 and `wait_cnt` increments each cycle.
  - `net_label_ready`=1: capture `net_label` into `result_label`, set `result_timeout`=0, go to RESULT.
  - Otherwise, when `wait_cnt` reaches TIMEOUT_CYCLES-1: set `result_label`=0 and `result_timeout`=1, pulse `net_reset` for 1 cycle, go to RESULT.
  - Label and expiry in the same cycle: the label wins.
- **RESULT:** `result_valid`=1; `result_label` and `result_timeout` are held stable.
  - A handshake returns to IDLE with `load_idx`=0.
  - Loads and `start` are ignored.
- `net_pixels` is 0 whenever `net_image_ready`=0.
- Buffer contents persist across inferences; the host must reload all NUM_PIXELS pixels for each run.

## Timing
- While `reset_n`=0: state goes to IDLE; `load_idx`, `beat_idx`, `wait_cnt` = 0; `net_reset`=1.
- All other outputs are 0 during reset except `load_ready`, which is IDLE-decoded and is 1.
- Buffer contents are not reset.
- Reset mid-operation, in any state, aborts the run with the behaviour above. No result is produced.
- All outputs are registered or decoded from registered state. No input reaches an output combinationally.
- With `start` sampled high at edge t (state LOADED):
  - `net_reset`=1 in cycle t+1.
  - Beats occupy cycles t+2 .. t+1+NUM_BEATS.
  - WAIT begins at t+2+NUM_BEATS.
- `net_label_ready` sampled at edge w in WAIT gives `result_valid`=1 from cycle w+1.
- Timeout: `result_valid` rises exactly TIMEOUT_CYCLES cycles after WAIT entry.
- A result handshake at edge r gives `load_ready`=1 from cycle r+1.
- A back-to-back inference is possible with no other idle cycles.

## Test plan
- **Defaults, nominal run.** Load pixels i<<16 for i=0..9, then start. Expect:
  - `net_reset` for 1 cycle, then 10 beats carrying 0..9 in order.
  - Bench network asserts `net_label_ready` with label 7 on WAIT cycle 5.
  - `result_valid`=1 one cycle later with `result_label`=7 and `result_timeout`=0.
- **INPUT_SIZE=3, NUM_PIXELS=10.** Expect exactly 4 beats; beat 3 is {9,0,0}; `net_image_ready` is never high for a 5th cycle.
- **Timeout, TIMEOUT_CYCLES=16, no label.** Expect `result_valid` 16 cycles after WAIT entry, `result_timeout`=1, `result_label`=0, and `net_reset` pulsed once.
- **Result backpressure.** Hold `result_ready`=0 for 5 cycles. Expect `result_valid`, `result_label` and `result_timeout` stable throughout; `load_ready`=0 until the cycle after the handshake.
- **Protocol misuse.** `start` after only 6 loads: expect no `net_reset` and no beats. Loads asserted during STREAM/WAIT: expect `load_ready`=0 and buffer unchanged. `net_label_ready` during STREAM: expect it to be ignored.
- **Reset mid-stream.** Assert `reset_n`=0 on beat 4. Expect `net_image_ready`=0, `net_reset`=1 and `load_ready`=1 in the following cycle. A fresh load and run then completes correctly.
